// File: rtl/mod_delay_line_pkg.sv
// Shared definitions for the LFO-modulated delay line.
// Latency: n/a (types, constants and a saturation helper only).
// Backpressure: n/a.
//   Contents: default widths, FSM state encoding, signed saturation helper.
package mod_delay_line_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_RD    = 3'd2,
        ST_MIX   = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    // Signed saturation of a 32-bit value to a w-bit signed range.
    // The result is returned sign-extended to 32 bits; callers keep the low w bits.
    function automatic logic signed [31:0] sat_s(input logic signed [31:0] v,
                                                 input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/mod_delay_line_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Latency: read data appears one clock after the read address is presented.
// Backpressure: none; writes and reads are accepted every cycle. No reset.
//   Ports: clk, we/wr_addr/wr_data (write), rd_addr/rd_data (read).
module delay_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mod_delay_line.sv
// LFO-modulated delay line (chorus/vibrato): circular buffer, modulated tap, dry/wet mix.
// Latency: out_valid pulses in the 3rd cycle after the accepting edge; 1 sample per 4 clocks max.
// Backpressure: in_ready low while clearing and while a sample is in flight; drops set sticky overrun.
//   Ports: clk/rst_n, in_valid/in_ready/in_sample, lfo_valid/lfo_val, depth_sh, base_delay, mix,
//   out_valid/out_sample, overrun; fb_gain only when FEEDBACK_EN is defined (buffer feedback path).
module mod_delay_line
    import mod_delay_line_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic                     lfo_valid,
    input  logic [5:0]               lfo_val,
    input  logic [1:0]               depth_sh,
    input  logic [ADDR_W-1:0]        base_delay,
    input  logic [7:0]               mix,
`ifdef FEEDBACK_EN
    input  logic [7:0]               fb_gain,
`endif
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     overrun
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int ACC_W = DATA_W + 10;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]        wr_ptr;
    logic [ADDR_W-1:0]        clr_addr;
    logic [ADDR_W-1:0]        rd_addr_q;
    logic [5:0]               lfo_hold;
    logic signed [DATA_W-1:0] dry_q;

    logic [ADDR_W:0]          lfo_off;
    logic [ADDR_W:0]          dly_sum;
    logic [ADDR_W-1:0]        dly;
    logic [ADDR_W-1:0]        rd_addr_c;

    logic                     ram_we;
    logic [ADDR_W-1:0]        ram_waddr;
    logic signed [DATA_W-1:0] ram_wdata;
    logic signed [DATA_W-1:0] wet;

    logic [8:0]               dry_wt;
    logic [8:0]               wet_wt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [31:0]       acc_sh;
    logic signed [31:0]       mix_sat;

    // Delay tap: saturate to the buffer length, and never let it reach 0 so the
    // read in RD can never alias the write of the current sample.
    always_comb begin
        lfo_off = (ADDR_W+1)'(lfo_hold) << depth_sh;
        dly_sum = {1'b0, base_delay} + lfo_off;
        if (dly_sum > (ADDR_W+1)'(DEPTH - 1))
            dly = '1;
        else if (dly_sum == '0)
            dly = ADDR_W'(1);
        else
            dly = dly_sum[ADDR_W-1:0];
        rd_addr_c = wr_ptr - dly;
    end

    // Mixer: wet is the registered RAM output, valid while in MIX.
    always_comb begin
        dry_wt = 9'd256 - {1'b0, mix};
        wet_wt = {1'b0, mix};
        acc    = $signed({{10{dry_q[DATA_W-1]}}, dry_q}) * $signed({{(DATA_W+1){1'b0}}, dry_wt})
               + $signed({{10{wet[DATA_W-1]}}, wet})     * $signed({{(DATA_W+1){1'b0}}, wet_wt});
        acc_sh  = 32'(acc) >>> 8;
        mix_sat = sat_s(acc_sh, DATA_W);
    end

`ifdef FEEDBACK_EN
    logic signed [DATA_W-1:0] wet_q;
    logic signed [31:0]       fb_prod;
    logic signed [31:0]       fb_sum;
    logic signed [31:0]       fb_sat;

    always_comb begin
        fb_prod = 32'(wet_q) * 32'($signed({1'b0, fb_gain}));
        fb_sum  = (fb_prod >>> 8) + 32'(dry_q);
        fb_sat  = sat_s(fb_sum, DATA_W);
    end
`endif

    // Buffer write port: zero-fill while clearing, otherwise the current sample.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_ptr;
        ram_wdata = dry_q;
        case (state)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr;
                ram_wdata = '0;
            end
`ifdef FEEDBACK_EN
            // Deferred to OUT so the feedback term can use the wet sample.
            ST_OUT: begin
                ram_we    = 1'b1;
                ram_wdata = fb_sat[DATA_W-1:0];
            end
`else
            ST_RD: ram_we = 1'b1;
`endif
            default: ;
        endcase
    end

    delay_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_addr (rd_addr_q),
        .rd_data (wet)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_CLEAR;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_addr == ADDR_W'(DEPTH - 1)) state_nxt = ST_IDLE;
            ST_IDLE:  if (in_valid) state_nxt = ST_RD;
            ST_RD:    state_nxt = ST_MIX;
            ST_MIX:   state_nxt = ST_OUT;
            ST_OUT:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    assign in_ready = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            clr_addr   <= '0;
            rd_addr_q  <= '0;
            lfo_hold   <= '0;
            dry_q      <= '0;
            out_valid  <= 1'b0;
            out_sample <= '0;
            overrun    <= 1'b0;
`ifdef FEEDBACK_EN
            wet_q      <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            if (lfo_valid)
                lfo_hold <= lfo_val;
            if (in_valid && !in_ready)
                overrun <= 1'b1;
            case (state)
                // Wraps back to 0 on the last address, ready for the next clear.
                ST_CLEAR: clr_addr <= clr_addr + ADDR_W'(1);
                ST_IDLE: begin
                    if (in_valid) begin
                        dry_q     <= in_sample;
                        rd_addr_q <= rd_addr_c;
                    end
                end
                // Output registers load on the MIX->OUT edge so out_valid is high during OUT.
                ST_MIX: begin
                    out_valid  <= 1'b1;
                    out_sample <= mix_sat[DATA_W-1:0];
`ifdef FEEDBACK_EN
                    wet_q      <= wet;
`endif
                end
                ST_OUT: wr_ptr <= wr_ptr + ADDR_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_delay_line.sv
// Directed bench for mod_delay_line: clear timing, mixing, delay saturation/clamp,
// pointer wrap, overrun and reset during operation.
module tb_mod_delay_line;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_sample = '0;
    logic               lfo_valid = 1'b0;
    logic [5:0]         lfo_val = '0;
    logic [1:0]         depth_sh = '0;
    logic [9:0]         base_delay = '0;
    logic [7:0]         mix = '0;
    logic               out_valid;
    logic signed [15:0] out_sample;
    logic               overrun;
`ifdef FEEDBACK_EN
    logic [7:0]         fb_gain = '0;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod_delay_line dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sample  (in_sample),
        .lfo_valid  (lfo_valid),
        .lfo_val    (lfo_val),
        .depth_sh   (depth_sh),
        .base_delay (base_delay),
        .mix        (mix),
`ifdef FEEDBACK_EN
        .fb_gain    (fb_gain),
`endif
        .out_valid  (out_valid),
        .out_sample (out_sample),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    // Releases reset on a falling edge; returns clocks until in_ready is seen.
    task automatic release_and_wait(output int n);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 1200);
    endtask

    task automatic do_reset(output int n);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        release_and_wait(n);
    endtask

    task automatic set_lfo(input logic [5:0] v);
        lfo_val   = v;
        lfo_valid = 1'b1;
        @(negedge clk);
        lfo_valid = 1'b0;
    endtask

    // Sends one sample and returns the output plus the cycle count from acceptance.
    task automatic send(input logic signed [15:0] s, output logic signed [15:0] got,
                        output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready)
            chk("ready_wait", 32'(in_ready), 1);
        in_valid  = 1'b1;
        in_sample = s;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        got = out_sample;
    endtask

    logic signed [15:0] got;
    logic signed [15:0] exp_s;
    int lat;
    int n;
    int bad;
    int vcount;

    initial begin
        // Reset state while rst_n is held low.
        repeat (2) @(negedge clk);
        chk("rst_in_ready",   32'(in_ready),   0);
        chk("rst_out_valid",  32'(out_valid),  0);
        chk("rst_out_sample", 32'(out_sample), 0);
        chk("rst_overrun",    32'(overrun),    0);

        release_and_wait(n);
        chk("clear_cycles", n, 1024);

        // Cleared buffer: wet is zero, dry weight 1/256 of 0x00FF truncates to 0.
        mix = 8'd255;
        send(16'sh00FF, got, lat);
        chk("mix255_cleared", got, 0);
        chk("mix255_lat", lat, 3);

        mix = 8'd0;
        send(16'sh1234, got, lat);
        chk("mix0_pos", got, 16'sh1234);
        chk("mix0_lat", lat, 3);
        send(-16'sh1234, got, lat);
        chk("mix0_neg", got, -16'sh1234);

        // Impulse with mix=128, delay 4.
        do_reset(n);
        chk("clear_cycles2", n, 1024);
        mix = 8'd128;
        base_delay = 10'd4;
        depth_sh = 2'd0;
        set_lfo(6'd0);
        for (int k = 0; k < 8; k++) begin
            send((k == 0) ? 16'sh4000 : 16'sh0000, got, lat);
            exp_s = (k == 0 || k == 4) ? 16'sh2000 : 16'sh0000;
            chk($sformatf("impulse_%0d", k), got, exp_s);
        end

        // Zero delay clamps to 1 (wr_ptr is 8, buffer holds only addr 0 marker).
        base_delay = 10'd0;
        send(16'sh4000, got, lat);
        chk("clamp_dry", got, 16'sh2000);
        send(16'sh0000, got, lat);
        chk("clamp_echo", got, 16'sh2000);
        send(16'sh0000, got, lat);
        chk("clamp_after", got, 0);

        // Drop a sample offered during RD.
        chk("overrun_before", 32'(overrun), 0);
        while (!in_ready) @(negedge clk);
        in_valid = 1'b1;
        in_sample = 16'sh0100;
        @(negedge clk);
        in_sample = 16'sh7FFF;
        @(negedge clk);
        in_valid = 1'b0;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) vcount++;
            @(negedge clk);
        end
        chk("overrun_set", 32'(overrun), 1);
        chk("overrun_one_out", vcount, 1);
        send(16'sh0000, got, lat);
        chk("overrun_sticky", 32'(overrun), 1);

        // Reset asserted during MIX: no output, clear restarts.
        while (!in_ready) @(negedge clk);
        in_valid = 1'b1;
        in_sample = 16'sh1000;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("midreset_no_out", vcount, 0);
        chk("midreset_overrun", 32'(overrun), 0);
        release_and_wait(n);
        chk("clear_cycles3", n, 1024);

        // Saturated delay (1020 + 63<<3 -> 1023) then wrap with delay 8.
        mix = 8'd128;
        base_delay = 10'd1020;
        depth_sh = 2'd3;
        set_lfo(6'd63);
        bad = 0;
        for (int k = 0; k < 1100; k++) begin
            if (k == 1024) begin
                base_delay = 10'd8;
                depth_sh = 2'd0;
                set_lfo(6'd0);
            end
            send((k == 0 || k == 1020) ? 16'sh4000 : 16'sh0000, got, lat);
            if (k == 0 || k == 1020 || k == 1023 || k == 1028)
                chk($sformatf("wrap_marker_%0d", k), got, 16'sh2000);
            else if (got != 16'sh0000 || lat != 3)
                bad++;
        end
        chk("wrap_others_zero", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
